// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting ports A/B onto one tristate memory bus; ack follows the sampling edge by 1 (write), 2 (read) or 0 (reserved addr) cycles.
// Flow control: a requester holds req until its one-cycle ack; requests are only sampled in IDLE, so a loser waits one IDLE cycle.
module mem_arbiter #(
    parameter int VALID_ADDRS = 6
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         reqA,
    input  logic         rwA,
    input  logic [2:0]   addrA,
    input  logic [255:0] wdataA,
    input  logic         reqB,
    input  logic         rwB,
    input  logic [2:0]   addrB,
    input  logic [255:0] wdataB,
    output logic         ackA,
    output logic         ackB,
    output logic         err,
    output logic [255:0] rdata,
    output logic         busy,
    output logic         nEnable,
    output logic         ReadWrite,
    output logic [2:0]   address,
    inout  wire  [255:0] dataBus
);

    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ACK} state_t;

    localparam logic [3:0] ADDR_LIMIT = 4'(VALID_ADDRS);

    state_t         state;
    logic           lastGrantB;
    logic [255:0]   wdataHeld;

    logic           pickB;
    logic           selRw;
    logic           selReserved;
    logic [2:0]     selAddr;
    logic [255:0]   selData;

    // B wins only when alone or when A was served last.
    always_comb begin
        pickB       = reqB && (!reqA || !lastGrantB);
        selRw       = pickB ? rwB : rwA;
        selAddr     = pickB ? addrB : addrA;
        selData     = pickB ? wdataB : wdataA;
        selReserved = ({1'b0, selAddr} >= ADDR_LIMIT);
    end

    assign busy    = (state != IDLE);
    assign dataBus = (state == WR) ? wdataHeld : {256{1'bz}};

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            lastGrantB <= 1'b1;
            wdataHeld  <= '0;
            nEnable    <= 1'b1;
            ReadWrite  <= 1'b1;
            address    <= '0;
            ackA       <= 1'b0;
            ackB       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            ackA <= 1'b0;
            ackB <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqA || reqB) begin
                        lastGrantB <= pickB;
                        address    <= selAddr;
                        wdataHeld  <= selData;
                        if (selReserved) begin
                            state <= ACK;
                            err   <= 1'b1;
                            ackA  <= !pickB;
                            ackB  <= pickB;
                        end else begin
                            nEnable   <= 1'b0;
                            ReadWrite <= selRw;
                            state     <= selRw ? RD1 : WR;
                        end
                    end
                end
                WR: begin
                    state     <= ACK;
                    nEnable   <= 1'b1;
                    ReadWrite <= 1'b1;
                    ackA      <= !lastGrantB;
                    ackB      <= lastGrantB;
                end
                RD1: begin
                    state <= RD2;
                end
                RD2: begin
                    state     <= ACK;
                    rdata     <= dataBus;
                    nEnable   <= 1'b1;
                    ReadWrite <= 1'b1;
                    ackA      <= !lastGrantB;
                    ackB      <= lastGrantB;
                end
                ACK: begin
                    state <= IDLE;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: simple memory device on the tristate bus plus a transaction-level model.
module tb_mem_arbiter;

    localparam int VALID = 6;

    logic         clk = 1'b0;
    logic         nReset;
    logic         reqA, rwA, reqB, rwB;
    logic [2:0]   addrA, addrB;
    logic [255:0] wdataA, wdataB;
    logic         ackA, ackB, err, busy, nEnable, ReadWrite;
    logic [255:0] rdata;
    logic [2:0]   address;
    wire  [255:0] dataBus;

    logic [255:0] memArr [8];
    logic         memClear;

    logic [255:0] modelMem [8];
    logic [255:0] modelRdata;
    bit           modelLastB;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit           isB;
        bit           rw;
        logic [2:0]   addr;
        logic [255:0] wdata;
        int           expLat;
        bit           expErr;
        logic [255:0] expRd;
    } vec_t;

    vec_t vecs [11];

    mem_arbiter #(.VALID_ADDRS(VALID)) dut (
        .clk(clk), .nReset(nReset),
        .reqA(reqA), .rwA(rwA), .addrA(addrA), .wdataA(wdataA),
        .reqB(reqB), .rwB(rwB), .addrB(addrB), .wdataB(wdataB),
        .ackA(ackA), .ackB(ackB), .err(err), .rdata(rdata), .busy(busy),
        .nEnable(nEnable), .ReadWrite(ReadWrite), .address(address),
        .dataBus(dataBus)
    );

    initial forever #5 clk = ~clk;

    // Memory device: drives the bus while enabled for read, stores on enabled write edges.
    assign dataBus = (!nEnable && ReadWrite) ? memArr[address] : {256{1'bz}};

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 8; i++) memArr[i] <= '0;
        end else if (!nEnable && !ReadWrite) begin
            memArr[address] <= dataBus;
        end
    end

    task automatic checkV(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic checkI(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic checkB(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkB({tag, "_nEnable"}, nEnable, 1'b1);
        checkB({tag, "_ReadWrite"}, ReadWrite, 1'b1);
        checkI({tag, "_address"}, int'(address), 0);
        checkB({tag, "_ackA"}, ackA, 1'b0);
        checkB({tag, "_ackB"}, ackB, 1'b0);
        checkB({tag, "_err"}, err, 1'b0);
        checkB({tag, "_busy"}, busy, 1'b0);
        checkV({tag, "_rdata"}, rdata, '0);
    endtask

    task automatic checkMem(input string tag);
        for (int i = 0; i < 8; i++)
            checkV($sformatf("%s_mem%0d", tag, i), memArr[i], modelMem[i]);
    endtask

    task automatic modelReset();
        modelRdata = '0;
        modelLastB = 1'b1;
    endtask

    function automatic logic [255:0] randData();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Single-port transaction; reports what was observed for the table checks.
    task automatic oneTxn(input bit isB, input bit rw, input logic [2:0] a, input logic [255:0] d,
                          output int lat, output bit gotErr, output logic [255:0] gotRd,
                          output bit enLow, output logic [255:0] busSeen, output int addrSeen,
                          output bit otherAck);
        lat = -1; gotErr = 0; gotRd = '0; enLow = 0; busSeen = '0; addrSeen = -1; otherAck = 0;
        @(negedge clk);
        if (isB) begin reqB = 1; rwB = rw; addrB = a; wdataB = d; end
        else     begin reqA = 1; rwA = rw; addrA = a; wdataA = d; end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (!nEnable) begin
                enLow = 1;
                addrSeen = int'(address);
                if (!ReadWrite) busSeen = dataBus;
            end
            if (isB ? ackA : ackB) otherAck = 1;
            if (isB ? ackB : ackA) begin
                lat = c; gotErr = err; gotRd = rdata;
                break;
            end
        end
        @(posedge clk); #1;
        reqA = 0; reqB = 0;
    endtask

    // One or two simultaneous requesters, checked against the transaction model.
    task automatic runRound(input string tag, input bit doA, input bit doB,
                            input bit rwa, input logic [2:0] aa, input logic [255:0] da,
                            input bit rwb, input logic [2:0] ab, input logic [255:0] db);
        bit           order [2];
        int           n, got, lat;
        int           expCyc [2];
        bit           expErrV [2];
        logic [255:0] expRd [2];
        bit           evB [2];
        int           evCyc [2];
        bit           evErr [2];
        logic [255:0] evRd [2];
        bit           hitA, hitB, isB, rw, bad;
        logic [2:0]   a;
        logic [255:0] d;

        n = 0;
        if (doA && doB) begin order[0] = !modelLastB; order[1] = modelLastB; n = 2; end
        else if (doA)   begin order[0] = 1'b0; n = 1; end
        else if (doB)   begin order[0] = 1'b1; n = 1; end

        for (int i = 0; i < n; i++) begin
            isB = order[i];
            rw  = isB ? rwb : rwa;
            a   = isB ? ab : aa;
            d   = isB ? db : da;
            bad = int'(a) >= VALID;
            lat = bad ? 0 : (rw ? 2 : 1);
            expCyc[i]  = (i == 0) ? lat : expCyc[0] + 2 + lat;
            expErrV[i] = bad;
            if (!bad && rw) modelRdata = modelMem[a];
            else if (!bad)  modelMem[a] = d;
            expRd[i]   = modelRdata;
            modelLastB = isB;
        end

        @(negedge clk);
        reqA = doA; rwA = rwa; addrA = aa; wdataA = da;
        reqB = doB; rwB = rwb; addrB = ab; wdataB = db;
        got = 0;
        for (int c = 0; c < 30 && got < n; c++) begin
            @(negedge clk);
            hitA = 0; hitB = 0;
            if (ackA && got < 2) begin
                evB[got] = 0; evCyc[got] = c; evErr[got] = err; evRd[got] = rdata; got++; hitA = 1;
            end
            if (ackB && got < 2) begin
                evB[got] = 1; evCyc[got] = c; evErr[got] = err; evRd[got] = rdata; got++; hitB = 1;
            end
            if (hitA || hitB) begin
                @(posedge clk); #1;
                if (hitA) reqA = 0;
                if (hitB) reqB = 0;
            end
        end
        reqA = 0; reqB = 0;

        checkI({tag, "_ackCount"}, got, n);
        for (int i = 0; i < n && i < got; i++) begin
            checkB($sformatf("%s_port%0d", tag, i), evB[i], order[i]);
            checkI($sformatf("%s_cycle%0d", tag, i), evCyc[i], expCyc[i]);
            checkB($sformatf("%s_err%0d", tag, i), evErr[i], expErrV[i]);
            checkV($sformatf("%s_rdata%0d", tag, i), evRd[i], expRd[i]);
        end
        checkMem(tag);
    endtask

    initial begin
        int           lat, addrSeen;
        bit           gotErr, enLow, otherAck, doA, doB;
        logic [255:0] gotRd, busSeen;

        nReset = 0; memClear = 1;
        reqA = 0; rwA = 0; addrA = '0; wdataA = '0;
        reqB = 0; rwB = 0; addrB = '0; wdataB = '0;
        for (int i = 0; i < 8; i++) modelMem[i] = '0;
        modelReset();

        repeat (2) @(negedge clk);
        memClear = 0;
        checkResetOutputs("reset");
        @(negedge clk);
        nReset = 1;

        // Simultaneous requests straight out of reset: A must win the first tie.
        runRound("tieFromReset", 1, 1, 1, 3'd3, '0, 0, 3'd4, 256'hF00D);

        vecs[0]  = '{0, 0, 3'd3, 256'h1234, 1, 0, 256'h0};
        vecs[1]  = '{0, 1, 3'd3, 256'h0,    2, 0, 256'h1234};
        vecs[2]  = '{1, 1, 3'd6, 256'h0,    0, 1, 256'h1234};
        vecs[3]  = '{1, 1, 3'd4, 256'h0,    2, 0, 256'hF00D};
        vecs[4]  = '{1, 0, 3'd7, 256'hDEAD, 0, 1, 256'hF00D};
        vecs[5]  = '{0, 0, 3'd0, 256'hABCD, 1, 0, 256'hF00D};
        vecs[6]  = '{0, 1, 3'd0, 256'h0,    2, 0, 256'hABCD};
        vecs[7]  = '{0, 1, 3'd5, 256'h0,    2, 0, 256'h0};
        vecs[8]  = '{1, 0, 3'd5, 256'h55,   1, 0, 256'h0};
        vecs[9]  = '{1, 1, 3'd5, 256'h0,    2, 0, 256'h55};
        vecs[10] = '{0, 1, 3'd7, 256'h0,    0, 1, 256'h55};

        for (int v = 0; v < 11; v++) begin
            oneTxn(vecs[v].isB, vecs[v].rw, vecs[v].addr, vecs[v].wdata,
                   lat, gotErr, gotRd, enLow, busSeen, addrSeen, otherAck);
            checkI($sformatf("vec%0d_latency", v), lat, vecs[v].expLat);
            checkB($sformatf("vec%0d_err", v), gotErr, vecs[v].expErr);
            checkV($sformatf("vec%0d_rdata", v), gotRd, vecs[v].expRd);
            checkB($sformatf("vec%0d_enableLow", v), enLow, !vecs[v].expErr);
            checkI($sformatf("vec%0d_memAddr", v), addrSeen, vecs[v].expErr ? -1 : int'(vecs[v].addr));
            checkV($sformatf("vec%0d_busWrite", v), busSeen,
                   (!vecs[v].rw && !vecs[v].expErr) ? vecs[v].wdata : 256'h0);
            checkB($sformatf("vec%0d_otherAck", v), otherAck, 1'b0);
            if (!vecs[v].rw && !vecs[v].expErr) modelMem[vecs[v].addr] = vecs[v].wdata;
            if (vecs[v].rw && !vecs[v].expErr) modelRdata = modelMem[vecs[v].addr];
            modelLastB = vecs[v].isB;
        end
        checkMem("table");

        // Reset during WR aborts the write.
        @(negedge clk);
        reqA = 1; rwA = 0; addrA = 3'd2; wdataA = 256'hBEEF;
        @(posedge clk); #2;
        checkB("wrAbort_inWr", nEnable, 1'b0);
        nReset = 0; #1;
        checkResetOutputs("wrAbort");
        modelReset();
        @(negedge clk); reqA = 0;
        @(negedge clk); nReset = 1;
        repeat (3) begin
            @(negedge clk);
            checkB("wrAbort_noAck", ackA, 1'b0);
            checkB("wrAbort_idle", busy, 1'b0);
        end
        runRound("afterWrAbort", 1, 0, 1, 3'd0, '0, 0, 3'd0, '0);

        // Reset pulsed mid-RD2.
        @(negedge clk);
        reqA = 1; rwA = 1; addrA = 3'd4;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkB("rd2_enable", nEnable, 1'b0);
        checkB("rd2_dir", ReadWrite, 1'b1);
        #2 nReset = 0; #1;
        checkResetOutputs("rd2Reset");
        modelReset();
        @(negedge clk); reqA = 0;
        @(negedge clk); nReset = 1;
        repeat (3) begin
            @(negedge clk);
            checkB("rd2Reset_noAck", ackA, 1'b0);
        end
        runRound("afterRd2Reset", 0, 1, 0, 3'd0, '0, 1, 3'd5, '0);

        for (int r = 0; r < 150; r++) begin
            doA = ($urandom_range(0, 2) != 0);
            doB = ($urandom_range(0, 2) != 0);
            if (!doA && !doB) doA = 1;
            runRound($sformatf("rnd%0d", r), doA, doB,
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), randData(),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), randData());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
